// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared widths, FSM state and writeback payload type for the register-file write arbiter.
package rf_arb_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS = 32;
  typedef enum logic {ST_CLEAR, ST_RUN} arb_state_e;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       wd;
  } wb_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr_i and wrapping at NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IW-1:0]      ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      idx_o
);
  logic found;
  int j;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NUM_REQ) j -= NUM_REQ;
      if (en_i && !found && valid_i[j]) begin
        gnt_o[j] = 1'b1;
        idx_o = IW'(j);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: clears x1..x31 after reset, then round-robin arbitrates writebacks onto the register file port.
// Optional RF_WB_ARB_STATS_EN adds a saturating 16-bit stall counter on stall_cnt_o.
module rf_wb_arbiter
  import rf_arb_pkg::arb_state_e;
  import rf_arb_pkg::ST_CLEAR;
  import rf_arb_pkg::ST_RUN;
#(
  parameter int NUM_REQ = 3,
  parameter int XLEN = rf_arb_pkg::XLEN,
  parameter int REG_ADDR_W = rf_arb_pkg::REG_ADDR_W,
  parameter int NUM_REGS = rf_arb_pkg::NUM_REGS
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] req_rd_i,
  input  logic [NUM_REQ*XLEN-1:0]       req_wd_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          regwrite_o,
  output logic [REG_ADDR_W-1:0]         rd_o,
  output logic [XLEN-1:0]               wd_o,
`ifdef RF_WB_ARB_STATS_EN
  output logic [15:0]                   stall_cnt_o,
`endif
  output logic                          init_done_o
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(NUM_REGS) + 1;
  arb_state_e state_q, state_d;
  logic [CW-1:0] clear_q, clear_d;
  logic [IW-1:0] ptr_q, ptr_d, gidx;
  logic [NUM_REQ-1:0] gnt;
  logic regwrite_q, regwrite_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d, rd_sel;
  logic [XLEN-1:0] wd_q, wd_d, wd_sel;
  logic clear_end;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .valid_i(req_valid_i),
    .ptr_i  (ptr_q),
    .en_i   (state_q == ST_RUN),
    .gnt_o  (gnt),
    .idx_o  (gidx)
  );

  assign clear_end = clear_q == CW'(NUM_REGS);
  assign rd_sel = req_rd_i[int'(gidx)*REG_ADDR_W +: REG_ADDR_W];
  assign wd_sel = req_wd_i[int'(gidx)*XLEN +: XLEN];

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q    <= ST_CLEAR;
      clear_q    <= CW'(1);
      ptr_q      <= '0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      clear_q    <= clear_d;
      ptr_q      <= ptr_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      wd_q       <= wd_d;
    end
  end

  always_comb state_d = (state_q == ST_CLEAR && clear_end) ? ST_RUN : state_q;

  // Clear and writeback share the one write port; x0 handshakes but never strobes.
  always_comb begin
    clear_d    = clear_q;
    ptr_d      = ptr_q;
    regwrite_d = 1'b0;
    rd_d       = rd_q;
    wd_d       = wd_q;
    if (state_q == ST_CLEAR) begin
      if (!clear_end) begin
        regwrite_d = 1'b1;
        rd_d       = REG_ADDR_W'(clear_q);
        wd_d       = '0;
        clear_d    = clear_q + 1'b1;
      end
    end else if (|gnt) begin
      regwrite_d = rd_sel != '0;
      rd_d       = rd_sel;
      wd_d       = wd_sel;
      ptr_d      = (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
    end
  end

  assign req_ready_o = gnt;
  assign regwrite_o  = regwrite_q;
  assign rd_o        = rd_q;
  assign wd_o        = wd_q;
  assign init_done_o = state_q == ST_RUN;

`ifdef RF_WB_ARB_STATS_EN
  logic [15:0] stall_q, stall_d;
  always_comb stall_d = (state_q == ST_RUN && |(req_valid_i & ~gnt) && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
  always_ff @(posedge clk_i) begin
    if (!reset_i) stall_q <= '0;
    else stall_q <= stall_d;
  end
  assign stall_cnt_o = stall_q;
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: randomized self-checking bench for rf_wb_arbiter against a queue-free behavioural model.
module tb_rf_wb_arbiter;
  logic clk = 1'b0;
  logic reset_i = 1'b0;
  logic [2:0] valid = '0;
  logic [14:0] rd_v = '0;
  logic [95:0] wd_v = '0;
  logic [2:0] ready;
  logic regwrite, init_done;
  logic [4:0] rd;
  logic [31:0] wd;
`ifdef RF_WB_ARB_STATS_EN
  logic [15:0] stall_cnt;
`endif
  int checks = 0;
  int passed = 0;
  int rr = 0;
  logic [4:0] last_rd = '0;
  logic [31:0] last_wd = '0;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk_i(clk), .reset_i(reset_i), .req_valid_i(valid), .req_rd_i(rd_v), .req_wd_i(wd_v),
    .req_ready_o(ready), .regwrite_o(regwrite), .rd_o(rd), .wd_o(wd),
`ifdef RF_WB_ARB_STATS_EN
    .stall_cnt_o(stall_cnt),
`endif
    .init_done_o(init_done)
  );

  function automatic int model_grant(logic [2:0] v, int p);
    for (int k = 0; k < 3; k++)
      if (v[(p + k) % 3]) return (p + k) % 3;
    return -1;
  endfunction

  function automatic logic [2:0] onehot(int g);
    return (g < 0) ? 3'b000 : 3'(1 << g);
  endfunction

  task automatic set_req(int n, logic [4:0] r, logic [31:0] d);
    rd_v[n*5 +: 5] = r;
    wd_v[n*32 +: 32] = d;
  endtask

  task automatic release_and_check_clear();
    reset_i = 1'b1;
    valid = 3'b111;
    for (int k = 1; k <= 31; k++) begin
      @(posedge clk); #1;
      checks++; if ({regwrite, rd, wd, init_done} !== {1'b1, 5'(k), 32'h0, 1'b0})
        $display("FAIL clear_edge%0d: got we=%b rd=%0d wd=%h done=%b want we=1 rd=%0d wd=0 done=0", k, regwrite, rd, wd, init_done, k);
      else passed++;
      checks++; if (ready !== 3'b000) $display("FAIL clear_ready%0d: got %b want 000", k, ready); else passed++;
    end
    @(posedge clk); #1;
    checks++; if ({regwrite, init_done} !== 2'b01)
      $display("FAIL clear_end: got we=%b done=%b want we=0 done=1", regwrite, init_done);
    else passed++;
    valid = '0;
    rr = 0; last_rd = 5'd31; last_wd = '0;
  endtask

  task automatic do_init();
    reset_i = 1'b0; valid = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_i = 1'b1;
    repeat (32) @(posedge clk);
    #1;
    rr = 0; last_rd = 5'd31; last_wd = '0;
  endtask

  task automatic test_reset();
    reset_i = 1'b0; valid = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({regwrite, rd, wd, init_done, ready} !== '0)
      $display("FAIL reset_state: got we=%b rd=%0d wd=%h done=%b rdy=%b want all 0", regwrite, rd, wd, init_done, ready);
    else passed++;
  endtask

  task automatic test_clear();
    release_and_check_clear();
  endtask

  task automatic test_single();
    set_req(0, 5'd5, 32'hDEADBEEF);
    valid = 3'b001; #1;
    checks++; if (ready !== 3'b001) $display("FAIL single_ready: got %b want 001", ready); else passed++;
    @(posedge clk); #1;
    valid = '0;
    checks++; if ({regwrite, rd, wd} !== {1'b1, 5'd5, 32'hDEADBEEF})
      $display("FAIL single_write: got we=%b rd=%0d wd=%h want we=1 rd=5 wd=deadbeef", regwrite, rd, wd);
    else passed++;
    rr = 1;
  endtask

  task automatic test_round_robin();
    logic [31:0] d [3];
    do_init();
    valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      int g;
      for (int n = 0; n < 3; n++) begin d[n] = $urandom; set_req(n, 5'(n + 1), d[n]); end
      #1;
      g = c % 3;
      checks++; if (ready !== onehot(g)) $display("FAIL rr_grant%0d: got %b want %b", c, ready, onehot(g)); else passed++;
      @(posedge clk); #1;
      checks++; if ({regwrite, rd, wd} !== {1'b1, 5'(g + 1), d[g]})
        $display("FAIL rr_write%0d: got we=%b rd=%0d wd=%h want we=1 rd=%0d wd=%h", c, regwrite, rd, wd, g + 1, d[g]);
      else passed++;
    end
    valid = '0;
    rr = 0;
  endtask

  task automatic test_x0();
    set_req(1, 5'd0, 32'h1234);
    valid = 3'b010; #1;
    checks++; if (ready !== 3'b010) $display("FAIL x0_ready: got %b want 010", ready); else passed++;
    @(posedge clk); #1;
    valid = '0;
    checks++; if ({regwrite, rd} !== {1'b0, 5'd0}) $display("FAIL x0_write: got we=%b rd=%0d want we=0 rd=0", regwrite, rd); else passed++;
    rr = 2; last_rd = 5'd0; last_wd = 32'h1234;
  endtask

  task automatic test_random();
    logic pend [3];
    logic [4:0] prd [3];
    logic [31:0] pwd [3];
    for (int n = 0; n < 3; n++) pend[n] = 1'b0;
    for (int c = 0; c < 200; c++) begin
      int g;
      logic [2:0] v;
      for (int n = 0; n < 3; n++)
        if (!pend[n] && $urandom_range(0, 1) == 1) begin
          pend[n] = 1'b1; prd[n] = 5'($urandom_range(0, 31)); pwd[n] = $urandom;
        end
      for (int n = 0; n < 3; n++) begin v[n] = pend[n]; set_req(n, prd[n], pwd[n]); end
      valid = v; #1;
      g = model_grant(v, rr);
      checks++; if (ready !== onehot(g)) $display("FAIL rand_grant%0d: got %b want %b", c, ready, onehot(g)); else passed++;
      @(posedge clk); #1;
      if (g >= 0) begin
        last_rd = prd[g]; last_wd = pwd[g]; pend[g] = 1'b0; rr = (g + 1) % 3;
      end
      checks++; if ({regwrite, rd, wd} !== {(g >= 0) && (last_rd != 0), last_rd, last_wd})
        $display("FAIL rand_write%0d: got we=%b rd=%0d wd=%h want we=%b rd=%0d wd=%h", c, regwrite, rd, wd, (g >= 0) && (last_rd != 0), last_rd, last_wd);
      else passed++;
    end
    valid = '0;
  endtask

  task automatic test_reset_mid_run();
    int g;
    set_req(2, 5'd7, 32'hCAFEF00D);
    valid = 3'b100; #1;
    g = model_grant(valid, rr);
    checks++; if (ready !== onehot(g)) $display("FAIL midrst_ready: got %b want %b", ready, onehot(g)); else passed++;
    reset_i = 1'b0;
    @(posedge clk); #1;
    checks++; if ({regwrite, rd, wd, init_done} !== '0)
      $display("FAIL midrst_nowrite: got we=%b rd=%0d wd=%h done=%b want all 0", regwrite, rd, wd, init_done);
    else passed++;
    release_and_check_clear();
  endtask

`ifdef RF_WB_ARB_STATS_EN
  task automatic test_stats();
    do_init();
    for (int n = 0; n < 3; n++) set_req(n, 5'(n + 1), $urandom);
    valid = 3'b111;
    repeat (10) @(posedge clk);
    #1;
    valid = '0;
    checks++; if (stall_cnt !== 16'd10) $display("FAIL stats_count: got %0d want 10", stall_cnt); else passed++;
    force dut.stall_q = 16'hFFFE;
    #1;
    release dut.stall_q;
    valid = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    valid = '0;
    checks++; if (stall_cnt !== 16'hFFFF) $display("FAIL stats_sat: got %h want ffff", stall_cnt); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_clear();
    test_single();
    test_round_robin();
    test_x0();
    test_random();
    test_reset_mid_run();
`ifdef RF_WB_ARB_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
